// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver: synchronises and deglitches the receiver output,
// times marks/spaces in microsecond ticks and decodes 32-bit frames and repeat codes.
module ir_nec_rx #(
    parameter int unsigned TICK_DIV       = 50,
    parameter int unsigned RX_INV         = 1,
    parameter int unsigned FILT_LEN       = 4,
    parameter int unsigned LEAD_MARK_MIN  = 8000,
    parameter int unsigned LEAD_SPACE_MIN = 4000,
    parameter int unsigned REP_SPACE_MIN  = 1800,
    parameter int unsigned BIT1_SPACE_MIN = 1000,
    parameter int unsigned TIMEOUT_US     = 12000,
    parameter int unsigned CHECK_EN       = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_ir_rx,
    output logic [31:0] o_data,
    output logic        o_valid,
    output logic        o_repeat,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned DUR_W  = 16;
    localparam int unsigned BIT_W  = 5;

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, DATA_MARK, DATA_SPACE, REP_MARK, CHECK
    } state_t;

    logic [DIV_W-1:0]  div_q;
    logic              tick_q;
    logic [1:0]        sync_q;
    logic              level_c;
    logic              filt_q;
    logic [FILT_W-1:0] fcnt_q;
    logic              mark_start_q;
    logic              mark_end_q;
    logic              any_edge_c;
    logic [DUR_W-1:0]  dur_q;
    state_t            state_q;
    logic [31:0]       shift_q;
    logic [BIT_W-1:0]  bitcnt_q;
    logic              frame_ok_q;
    logic [31:0]       data_q;
    logic              valid_q;
    logic              repeat_q;
    logic              err_q;
    logic              busy_q;
    logic              check_pass_c;
    logic              timeout_c;

    // 1 us timing tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (div_q == DIV_W'(TICK_DIV - 1)) begin
            div_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            div_q  <= div_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], i_ir_rx};
    end

    assign level_c = sync_q[1] ^ (RX_INV != 0);

    // Level accepted only after FILT_LEN consecutive differing ticks; edges strobe on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q       <= 1'b0;
            fcnt_q       <= '0;
            mark_start_q <= 1'b0;
            mark_end_q   <= 1'b0;
        end else begin
            mark_start_q <= 1'b0;
            mark_end_q   <= 1'b0;
            if (level_c == filt_q) begin
                fcnt_q <= '0;
            end else if (tick_q) begin
                if (fcnt_q == FILT_W'(FILT_LEN - 1)) begin
                    filt_q       <= level_c;
                    fcnt_q       <= '0;
                    mark_start_q <= level_c;
                    mark_end_q   <= ~level_c;
                end else begin
                    fcnt_q <= fcnt_q + FILT_W'(1);
                end
            end
        end
    end

    assign any_edge_c = mark_start_q | mark_end_q;

    // On an edge strobe dur_q still holds the length of the interval just finished
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    dur_q <= '0;
        else if (any_edge_c)           dur_q <= '0;
        else if (tick_q && dur_q != '1) dur_q <= dur_q + DUR_W'(1);
    end

    assign check_pass_c = (CHECK_EN == 0) || (shift_q[23:16] == ~shift_q[31:24]);
    assign timeout_c    = (state_q != IDLE) && !any_edge_c && (dur_q == DUR_W'(TIMEOUT_US));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            frame_ok_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            valid_q  <= 1'b0;
            repeat_q <= 1'b0;
            err_q    <= 1'b0;
            if (timeout_c) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                frame_ok_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (mark_start_q) begin
                        state_q <= LEAD_MARK;
                        busy_q  <= 1'b1;
                    end
                    LEAD_MARK: if (mark_end_q) begin
                        if (dur_q >= DUR_W'(LEAD_MARK_MIN)) begin
                            state_q <= LEAD_SPACE;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    LEAD_SPACE: if (mark_start_q) begin
                        if (dur_q >= DUR_W'(LEAD_SPACE_MIN)) begin
                            state_q  <= DATA_MARK;
                            bitcnt_q <= '0;
                        end else if (dur_q >= DUR_W'(REP_SPACE_MIN)) begin
                            state_q <= REP_MARK;
                        end else begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                            frame_ok_q <= 1'b0;
                        end
                    end
                    DATA_MARK: if (mark_end_q) state_q <= DATA_SPACE;
                    DATA_SPACE: if (mark_start_q) begin
                        shift_q  <= {(dur_q >= DUR_W'(BIT1_SPACE_MIN)), shift_q[31:1]};
                        bitcnt_q <= bitcnt_q + BIT_W'(1);
                        state_q  <= (bitcnt_q == BIT_W'(31)) ? CHECK : DATA_MARK;
                    end
                    CHECK: begin
                        if (check_pass_c) begin
                            data_q     <= shift_q;
                            valid_q    <= 1'b1;
                            frame_ok_q <= 1'b1;
                        end else begin
                            err_q      <= 1'b1;
                            frame_ok_q <= 1'b0;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    REP_MARK: if (mark_end_q) begin
                        repeat_q <= frame_ok_q;
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_repeat = repeat_q;
    assign o_err    = err_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Randomised NEC frame / repeat-code bench for ir_nec_rx with a transaction-level
// model of accepted frames, repeats and errors; timing is scaled down via parameters.
module tb_ir_nec_rx;

    localparam int unsigned TD    = 2;
    localparam int unsigned FL    = 4;
    localparam int unsigned LMM   = 200;
    localparam int unsigned LSM   = 100;
    localparam int unsigned RSM   = 45;
    localparam int unsigned B1    = 28;
    localparam int unsigned TMO   = 300;
    localparam int unsigned T_LM  = 225;
    localparam int unsigned T_LS  = 112;
    localparam int unsigned T_RS  = 56;
    localparam int unsigned T_BM  = 14;
    localparam int unsigned T_S0  = 14;
    localparam int unsigned T_S1  = 42;
    localparam int unsigned T_GAP = 60;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ir_rx = 1'b1;
    logic [31:0] o_data;
    logic        o_valid, o_repeat, o_err, o_busy;

    ir_nec_rx #(
        .TICK_DIV(TD), .RX_INV(1), .FILT_LEN(FL), .LEAD_MARK_MIN(LMM),
        .LEAD_SPACE_MIN(LSM), .REP_SPACE_MIN(RSM), .BIT1_SPACE_MIN(B1),
        .TIMEOUT_US(TMO), .CHECK_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_ir_rx(ir_rx), .o_data(o_data),
        .o_valid(o_valid), .o_repeat(o_repeat), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n_valid = 0, n_rep = 0, n_err = 0, viol = 0;
    int cyc = 0, err_cyc = 0, edge_cyc = 0;
    int exp_valid = 0, exp_rep = 0, exp_err = 0;
    logic [31:0] exp_data = '0;
    bit   frame_ok = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pe = 1'b0;

    // Pulse monitor: counts output strobes, flags overlap or stretched pulses
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_valid)  n_valid = n_valid + 1;
        if (o_repeat) n_rep   = n_rep + 1;
        if (o_err) begin
            n_err   = n_err + 1;
            err_cyc = cyc;
        end
        if (int'(o_valid) + int'(o_repeat) + int'(o_err) > 1) viol = viol + 1;
        if ((o_valid && pv) || (o_repeat && pr) || (o_err && pe)) viol = viol + 1;
        pv = o_valid;
        pr = o_repeat;
        pe = o_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input bit mark, input int unsigned ticks);
        if (ir_rx != logic'(!mark)) edge_cyc = cyc;
        ir_rx = logic'(!mark);
        repeat (ticks * TD) @(negedge clk);
    endtask

    function automatic int unsigned jit(input int unsigned base, input int unsigned j);
        return base - j + $urandom_range(2 * j, 0);
    endfunction

    task automatic send_frame(input logic [31:0] bits, input int nbits, input logic [31:0] gmask,
                              input int abort_bit, input int unsigned lm, input int unsigned ls);
        hold(1'b1, lm);
        hold(1'b0, ls);
        for (int i = 0; i < nbits; i++) begin
            int unsigned sp, a;
            hold(1'b1, jit(T_BM, 2));
            if (i == abort_bit) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
            if (i == nbits - 1 && nbits < 32) begin
                hold(1'b0, TMO + T_GAP);
            end else begin
                sp = bits[i] ? jit(T_S1, 3) : jit(T_S0, 2);
                if (gmask[i]) begin
                    a = sp / 2 - 1;
                    hold(1'b0, a);
                    hold(1'b1, 2);
                    hold(1'b0, sp - a - 2);
                end else begin
                    hold(1'b0, sp);
                end
            end
        end
        if (nbits == 32) begin
            hold(1'b1, jit(T_BM, 2));
            hold(1'b0, T_GAP);
        end
    endtask

    task automatic send_repeat();
        hold(1'b1, jit(T_LM, 5));
        hold(1'b0, jit(T_RS, 3));
        hold(1'b1, jit(T_BM, 2));
        hold(1'b0, T_GAP);
        if (frame_ok) exp_rep++;
    endtask

    // Full well-formed frame; the model accepts it iff the command complement matches
    task automatic do_frame(input logic [7:0] addr, input logic [7:0] addr_inv,
                            input logic [7:0] cmd, input logic [7:0] cmd_inv, input int ng);
        logic [31:0] bits, gmask;
        bits  = {cmd_inv, cmd, addr_inv, addr};
        gmask = '0;
        while ($countones(gmask) < ng) gmask[$urandom_range(31, 0)] = 1'b1;
        send_frame(bits, 32, gmask, -1, jit(T_LM, 5), jit(T_LS, 4));
        if (cmd_inv == ~cmd) begin
            exp_valid++;
            exp_data = bits;
            frame_ok = 1'b1;
        end else begin
            exp_err++;
            frame_ok = 1'b0;
        end
    endtask

    task automatic verify(input string tag);
        chk({tag, "_valid"},  32'(n_valid), 32'(exp_valid));
        chk({tag, "_repeat"}, 32'(n_rep),   32'(exp_rep));
        chk({tag, "_err"},    32'(n_err),   32'(exp_err));
        chk({tag, "_data"},   o_data,       exp_data);
        chk({tag, "_busy"},   32'(o_busy),  32'd0);
    endtask

    initial begin
        int meas;
        logic [7:0] a, c, ci;
        repeat (5) @(negedge clk);
        chk("rst_data",   o_data,          32'd0);
        chk("rst_valid",  32'(o_valid),    32'd0);
        chk("rst_repeat", 32'(o_repeat),   32'd0);
        chk("rst_err",    32'(o_err),      32'd0);
        chk("rst_busy",   32'(o_busy),     32'd0);
        rst_n = 1'b1;
        hold(1'b0, 20);

        do_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 0);
        verify("nec");
        chk("nec_word", o_data, 32'hBA45FF00);

        send_repeat();
        verify("rep");

        do_frame(8'h00, 8'hFF, 8'h45, 8'h00, 0);
        verify("badcmp");
        send_repeat();
        verify("badcmp_rep");

        do_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 5);
        verify("glitch");
        chk("glitch_word", o_data, 32'hBA45FF00);

        send_frame(32'hBA45FF00, 16, '0, -1, T_LM, T_LS);
        exp_err++;
        frame_ok = 1'b0;
        verify("trunc");
        meas = err_cyc - edge_cyc;
        chk("trunc_timeout_window",
            32'((meas >= int'(TMO * TD)) && (meas <= int'(TMO * TD + (FL + 3) * TD + 6))), 32'd1);

        send_frame(32'h12ED34CB, 32, '0, 10, T_LM, T_LS);
        exp_data = '0;
        frame_ok = 1'b0;
        verify("abort");
        do_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3, 0);
        verify("after_abort");

        send_frame(32'hBA45FF00, 32, '0, -1, 150, T_LS);
        verify("short_lead_mark");
        send_repeat();
        verify("short_lead_rep");

        send_frame(32'hBA45FF00, 32, '0, -1, T_LM, 30);
        exp_err++;
        frame_ok = 1'b0;
        verify("short_lead_space");

        for (int k = 0; k < 6; k++) begin
            a  = 8'($urandom_range(255, 0));
            c  = 8'($urandom_range(255, 0));
            ci = ($urandom_range(3, 0) == 0) ? (~c ^ (8'd1 << $urandom_range(7, 0))) : ~c;
            do_frame(a, 8'($urandom_range(255, 0)), c, ci, int'($urandom_range(5, 0)));
            verify("rnd");
            if ($urandom_range(1, 0) == 1) begin
                send_repeat();
                verify("rnd_rep");
            end
        end

        chk("pulse_rules", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
